control_sequencer: RTL and testbench

//  Hardwired control unit for the bus-based datapath. It is the driving end of the datapath's control interface.
//  It steps a fetch/decode/execute FSM and decodes IR[31:27] to produce every datapath strobe each cycle:

---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control FSM driving every datapath strobe.
// Optional build macro CTRL_SINGLE_STEP_EN adds a step input that holds the FSM in T0 until step=1.
module control_sequencer #(
    parameter int IR_W     = 32,
    parameter int OP_W     = 5,
    parameter int ALUSEL_W = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [IR_W-1:0]     IR,
    input  logic                CON,
    input  logic                stop,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic                PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, memWrite,
    output logic                Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout,
    output logic                IRin, conIn, InPortout, outPortin,
    output logic [ALUSEL_W-1:0] ALUselect,
    output logic                run,
    output logic [2:0]          tstep
);

    localparam logic [3:0] S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
                           S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9;

    localparam logic [OP_W-1:0] OP_LD   = 'h00, OP_LDI  = 'h01, OP_ST   = 'h02, OP_ADD  = 'h03,
                                OP_SUB  = 'h04, OP_AND  = 'h05, OP_OR   = 'h06, OP_SHR  = 'h07,
                                OP_SHRA = 'h08, OP_SHL  = 'h09, OP_ROR  = 'h0A, OP_ROL  = 'h0B,
                                OP_ADDI = 'h0C, OP_ANDI = 'h0D, OP_ORI  = 'h0E, OP_MUL  = 'h0F,
                                OP_DIV  = 'h10, OP_NEG  = 'h11, OP_NOT  = 'h12, OP_BR   = 'h13,
                                OP_JR   = 'h14, OP_JAL  = 'h15, OP_IN   = 'h16, OP_OUT  = 'h17,
                                OP_MFHI = 'h18, OP_MFLO = 'h19, OP_HALT = 'h1B;

    logic [3:0]          state, state_nxt;
    logic [OP_W-1:0]     op;
    logic [IR_W-OP_W-1:0] ir_unused;
    logic [2:0]          t, last_t;
    logic [ALUSEL_W-1:0] alu;
    logic                in_t, in_exec, step_go;
    logic                is_r, is_imm, is_md, is_un, is_mem;

    assign op        = IR[IR_W-1 -: OP_W];
    assign ir_unused = IR[IR_W-OP_W-1:0];
    assign in_t      = (state >= S_T0) && (state <= S_T7);
    assign in_exec   = (state >= S_T3) && (state <= S_T7);
    assign t         = 3'(state - 4'd1);

`ifdef CTRL_SINGLE_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b1;
`endif

    assign is_r   = (op >= OP_ADD)  && (op <= OP_ROL);
    assign is_imm = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_md  = (op == OP_MUL)  || (op == OP_DIV);
    assign is_un  = (op == OP_NEG)  || (op == OP_NOT);
    assign is_mem = (op == OP_LD)   || (op == OP_LDI) || (op == OP_ST);

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD, OP_ADDI: alu = ALUSEL_W'(0);
            OP_SUB:          alu = ALUSEL_W'(1);
            OP_AND, OP_ANDI: alu = ALUSEL_W'(2);
            OP_OR,  OP_ORI:  alu = ALUSEL_W'(3);
            OP_SHR:          alu = ALUSEL_W'(4);
            OP_SHRA:         alu = ALUSEL_W'(5);
            OP_SHL:          alu = ALUSEL_W'(6);
            OP_ROR:          alu = ALUSEL_W'(7);
            OP_ROL:          alu = ALUSEL_W'(8);
            OP_MUL:          alu = ALUSEL_W'(9);
            OP_DIV:          alu = ALUSEL_W'(10);
            OP_NEG:          alu = ALUSEL_W'(11);
            OP_NOT:          alu = ALUSEL_W'(12);
            default:         alu = '0;
        endcase
    end

    // Final T-step of each instruction class; nop/undefined/single-step classes end at T3.
    always_comb begin
        last_t = 3'd3;
        if (op == OP_LD || op == OP_ST)             last_t = 3'd7;
        else if (op == OP_LDI || is_r || is_imm)    last_t = 3'd5;
        else if (is_md || op == OP_BR)              last_t = 3'd6;
        else if (is_un || op == OP_JAL)             last_t = 3'd4;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = stop ? S_HALT : S_T0;
            S_HALT: state_nxt = S_HALT;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state == S_T0 && !step_go)          state_nxt = S_T0;
                else if (state == S_T3 && op == OP_HALT) state_nxt = S_HALT;
                else if (t >= last_t)                   state_nxt = stop ? S_HALT : S_T0;
                else                                    state_nxt = 4'(state + 4'd1);
            end
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_RST;
        else      state <= state_nxt;
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, memWrite} = '0;
        {Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout} = '0;
        {IRin, conIn, InPortout, outPortin} = '0;
        ALUselect = '0;
        run       = in_t;
        tstep     = in_t ? t : 3'd0;

        if (state == S_T0 && step_go) begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        end else if (state == S_T1) begin
            MDRread = 1'b1; MDRin = 1'b1;
        end else if (state == S_T2) begin
            MDRout = 1'b1; IRin = 1'b1;
        end else if (in_exec) begin
            if (is_r || is_imm) begin
                case (t)
                    3'd3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    3'd4: begin Grc = is_r; Rout = is_r; Cout = is_imm; ALUselect = alu; Zin = 1'b1; end
                    3'd5: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end else if (is_md) begin
                case (t)
                    3'd3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    3'd4: begin Grb = 1'b1; Rout = 1'b1; ALUselect = alu; Zin = 1'b1; end
                    3'd5: begin ZLowout = 1'b1; LOin = 1'b1; end
                    3'd6: begin ZHighout = 1'b1; HIin = 1'b1; end
                    default: ;
                endcase
            end else if (is_un) begin
                case (t)
                    3'd3: begin Grb = 1'b1; Rout = 1'b1; ALUselect = alu; Zin = 1'b1; end
                    3'd4: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end else if (is_mem) begin
                // Address is always base + C; the ALU add code is 0 so ALUselect stays at default.
                case (t)
                    3'd3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    3'd4: begin Cout = 1'b1; Zin = 1'b1; end
                    3'd5: begin
                        ZLowout = 1'b1;
                        Gra     = (op == OP_LDI);
                        Rin     = (op == OP_LDI);
                        MARin   = (op != OP_LDI);
                    end
                    3'd6: begin
                        MDRin   = 1'b1;
                        MDRread = (op == OP_LD);
                        Gra     = (op == OP_ST);
                        Rout    = (op == OP_ST);
                    end
                    3'd7: begin
                        MDRout   = (op == OP_LD);
                        Gra      = (op == OP_LD);
                        Rin      = (op == OP_LD);
                        memWrite = (op == OP_ST);
                    end
                    default: ;
                endcase
            end else if (op == OP_BR) begin
                case (t)
                    3'd3: begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
                    3'd4: begin PCout = 1'b1; Yin = 1'b1; end
                    3'd5: begin Cout = 1'b1; Zin = 1'b1; end
                    3'd6: begin ZLowout = CON; PCin = CON; end
                    default: ;
                endcase
            end else if (op == OP_JAL) begin
                case (t)
                    3'd3: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    3'd4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end else if (t == 3'd3) begin
                case (op)
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver pushes per-cycle expected strobe words,
// a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

    typedef logic [34:0] exp_t;
    typedef struct packed { logic [15:0] id; exp_t v; } sb_t;

    localparam exp_t M_GRA  = 35'd1 << 34, M_GRB   = 35'd1 << 33, M_GRC  = 35'd1 << 32, M_RIN   = 35'd1 << 31;
    localparam exp_t M_ROUT = 35'd1 << 30, M_BAOUT = 35'd1 << 29, M_COUT = 35'd1 << 28, M_PCOUT = 35'd1 << 27;
    localparam exp_t M_PCIN = 35'd1 << 26, M_INCPC = 35'd1 << 25, M_MARIN = 35'd1 << 24, M_MDRIN = 35'd1 << 23;
    localparam exp_t M_MDRRD = 35'd1 << 22, M_MDROUT = 35'd1 << 21, M_MEMWR = 35'd1 << 20, M_YIN = 35'd1 << 19;
    localparam exp_t M_ZIN  = 35'd1 << 18, M_ZLO   = 35'd1 << 17, M_ZHI  = 35'd1 << 16, M_HIIN  = 35'd1 << 15;
    localparam exp_t M_HIOUT = 35'd1 << 14, M_LOIN = 35'd1 << 13, M_LOOUT = 35'd1 << 12, M_IRIN = 35'd1 << 11;
    localparam exp_t M_CONIN = 35'd1 << 10, M_INP  = 35'd1 << 9,  M_OUTP = 35'd1 << 8,  M_RUN   = 35'd1 << 3;

    logic        clk = 1'b0, clr, CON, stop;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, memWrite;
    logic Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, IRin, conIn, InPortout, outPortin, run;
    logic [3:0]  ALUselect;
    logic [2:0]  tstep;
    exp_t        act;

    int   n_tests = 0, n_fail = 0;
    bit   chk_en = 1'b0;
    int   id_ctr = 0;
    sb_t  sb[$];
    exp_t mseq[$];

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread),
        .MDRout(MDRout), .memWrite(memWrite), .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .IRin(IRin), .conIn(conIn),
        .InPortout(InPortout), .outPortin(outPortin), .ALUselect(ALUselect), .run(run), .tstep(tstep)
    );

    always #5 clk = ~clk;

    assign act = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout,
                  memWrite, Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, IRin, conIn, InPortout,
                  outPortin, ALUselect, run, tstep};

    task automatic check(input string name, input int id, input exp_t a, input exp_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s id=%0d actual=%h expected=%h", name, id, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_underflow actual=empty expected=entry");
            end else begin
                sb_t s;
                s = sb.pop_front();
                check("cycle", int'(s.id), act, s.v);
            end
        end
    end

    function automatic exp_t A(input int code);
        return exp_t'(code) << 4;
    endfunction

    // Reference: list of strobe sets per T-step, straight from the instruction tables.
    task automatic model(input logic [31:0] ir, input logic con);
        logic [4:0] op;
        op = ir[31:27];
        mseq.delete();
        mseq.push_back(M_PCOUT | M_MARIN | M_INCPC);
        mseq.push_back(M_MDRRD | M_MDRIN);
        mseq.push_back(M_MDROUT | M_IRIN);
        if (op >= 5'h03 && op <= 5'h0B) begin
            mseq.push_back(M_GRB | M_ROUT | M_YIN);
            mseq.push_back(M_GRC | M_ROUT | M_ZIN | A(int'(op) - 3));
            mseq.push_back(M_ZLO | M_GRA | M_RIN);
        end else if (op >= 5'h0C && op <= 5'h0E) begin
            mseq.push_back(M_GRB | M_ROUT | M_YIN);
            mseq.push_back(M_COUT | M_ZIN | A(op == 5'h0C ? 0 : (op == 5'h0D ? 2 : 3)));
            mseq.push_back(M_ZLO | M_GRA | M_RIN);
        end else if (op == 5'h0F || op == 5'h10) begin
            mseq.push_back(M_GRA | M_ROUT | M_YIN);
            mseq.push_back(M_GRB | M_ROUT | M_ZIN | A(op == 5'h0F ? 9 : 10));
            mseq.push_back(M_ZLO | M_LOIN);
            mseq.push_back(M_ZHI | M_HIIN);
        end else if (op == 5'h11 || op == 5'h12) begin
            mseq.push_back(M_GRB | M_ROUT | M_ZIN | A(op == 5'h11 ? 11 : 12));
            mseq.push_back(M_ZLO | M_GRA | M_RIN);
        end else if (op <= 5'h02) begin
            mseq.push_back(M_GRB | M_BAOUT | M_YIN);
            mseq.push_back(M_COUT | M_ZIN);
            if (op == 5'h01) mseq.push_back(M_ZLO | M_GRA | M_RIN);
            else begin
                mseq.push_back(M_ZLO | M_MARIN);
                if (op == 5'h00) begin
                    mseq.push_back(M_MDRRD | M_MDRIN);
                    mseq.push_back(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    mseq.push_back(M_GRA | M_ROUT | M_MDRIN);
                    mseq.push_back(M_MEMWR);
                end
            end
        end else if (op == 5'h13) begin
            mseq.push_back(M_GRA | M_ROUT | M_CONIN);
            mseq.push_back(M_PCOUT | M_YIN);
            mseq.push_back(M_COUT | M_ZIN);
            mseq.push_back(con ? (M_ZLO | M_PCIN) : exp_t'(0));
        end else if (op == 5'h15) begin
            mseq.push_back(M_PCOUT | M_GRB | M_RIN);
            mseq.push_back(M_GRA | M_ROUT | M_PCIN);
        end else if (op == 5'h14) mseq.push_back(M_GRA | M_ROUT | M_PCIN);
        else if (op == 5'h16) mseq.push_back(M_INP | M_GRA | M_RIN);
        else if (op == 5'h17) mseq.push_back(M_GRA | M_ROUT | M_OUTP);
        else if (op == 5'h18) mseq.push_back(M_HIOUT | M_GRA | M_RIN);
        else if (op == 5'h19) mseq.push_back(M_LOOUT | M_GRA | M_RIN);
        else mseq.push_back(exp_t'(0));
        foreach (mseq[k]) mseq[k] = mseq[k] | M_RUN | exp_t'(k);
    endtask

    task automatic push_exp(input exp_t v);
        sb_t s;
        s.id = 16'(id_ctr);
        s.v  = v;
        sb.push_back(s);
        id_ctr++;
    endtask

    task automatic idle_zero(input int n);
        repeat (n) begin
            push_exp('0);
            @(posedge clk); #1;
        end
    endtask

    // Leaves the FSM in T0 at posedge+1.
    task automatic do_reset(input int n);
        clr = 1'b0; stop = 1'b0;
        idle_zero(n);
        clr = 1'b1;
        idle_zero(1);
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic con, input logic stp, output bit halted);
        IR = ir; CON = con; stop = stp;
        model(ir, con);
        foreach (mseq[k]) push_exp(mseq[k]);
        repeat (mseq.size()) begin @(posedge clk); #1; end
        stop = 1'b0;
        halted = (ir[31:27] == 5'h1B) || stp;
    endtask

    // Reset arrives while the DUT sits in T4 of a 6-step instruction.
    task automatic abort_instr(input logic [31:0] ir);
        IR = ir; CON = 1'b0; stop = 1'b0;
        model(ir, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(mseq[k]);
        repeat (4) begin @(posedge clk); #1; end
        check("pre_clr_tstep", 0, exp_t'(tstep), exp_t'(4));
        do_reset(2);
    endtask

    initial begin
        bit h;
        clr = 1'b0; IR = '0; CON = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_reset(3);
        abort_instr(32'h18918000);
        run_instr(32'h18918000, 1'b0, 1'b0, h);
        run_instr(32'h00900055, 1'b0, 1'b0, h);
        run_instr(32'h98000000, 1'b0, 1'b0, h);
        run_instr(32'h98000000, 1'b1, 1'b0, h);
        run_instr(32'h79A00000, 1'b0, 1'b0, h);
        run_instr(32'hD8000000, 1'b0, 1'b0, h);
        idle_zero(20);
        do_reset(2);
        run_instr(32'h18918000, 1'b0, 1'b1, h);
        idle_zero(5);
        do_reset(1);
        for (int i = 0; i < 250; i++) begin
            logic [4:0]  op;
            logic [31:0] ir;
            op = 5'($urandom_range(0, 31));
            ir = {op, 27'($urandom)};
            if ($urandom_range(0, 24) == 0) begin
                abort_instr({5'($urandom_range(3, 14)), 27'($urandom)});
            end else begin
                run_instr(ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), h);
                if (h) begin
                    idle_zero($urandom_range(1, 6));
                    do_reset($urandom_range(1, 3));
                end
            end
        end
        chk_en = 1'b0;
        check("sb_drain", 0, exp_t'(sb.size()), exp_t'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
